// File: rtl/knn_mem_bridge.sv
// Bridge from the KNN core's bit-addressed SDRAM port to Avalon-MM words.
// Optional stats counters: define KNN_MEM_BRIDGE_STATS_EN.
module knn_mem_bridge #(
    parameter int W          = 16,
    parameter int ADDR_W     = 25,
    parameter int AVM_ADDR_W = ADDR_W - $clog2(W),
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cl_read,
    input  logic [ADDR_W-1:0]     cl_readaddress,
    input  logic                  cl_write,
    input  logic [ADDR_W-1:0]     cl_writeaddress,
    input  logic [W-1:0]          cl_writedata,
    output logic                  cl_ready,
    output logic [W-1:0]          cl_readdata,
    output logic                  cl_readdatavalid,
    output logic                  cl_writedone,
    output logic                  cl_error,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [W-1:0]          avm_writedata,
    input  logic                  avm_waitrequest,
    input  logic [W-1:0]          avm_readdata,
`ifdef KNN_MEM_BRIDGE_STATS_EN
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes,
    output logic [31:0]           stat_stall_cycles,
`endif
    input  logic                  avm_readdatavalid
);

    localparam int LB = $clog2(W);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ
    } state_t;

    state_t                r_state, w_state;
    logic [AVM_ADDR_W-1:0] r_addr, w_addr;
    logic                  r_rd, w_rd;
    logic                  r_wr, w_wr;
    logic [W-1:0]          r_wdata, w_wdata;
    logic                  r_pv, w_pv;
    logic [AVM_ADDR_W-1:0] r_pa, w_pa;
    logic [W-1:0]          r_rdata, w_rdata;
    logic                  r_rdv, w_rdv;
    logic                  r_wdone, w_wdone;
    logic                  r_err, w_err;
    logic [CW-1:0]         r_cnt, w_cnt;

    logic                  w_rd_mis;
    logic                  w_wr_mis;
    logic [AVM_ADDR_W-1:0] w_ra;
    logic [AVM_ADDR_W-1:0] w_wa;
    logic                  w_to;

    assign w_rd_mis = |cl_readaddress[LB-1:0];
    assign w_wr_mis = |cl_writeaddress[LB-1:0];
    assign w_ra     = AVM_ADDR_W'(cl_readaddress >> LB);
    assign w_wa     = AVM_ADDR_W'(cl_writeaddress >> LB);
    assign w_to     = (r_cnt == CW'(TIMEOUT - 1));

    // State and datapath registers; reset kills strobes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_pv    <= 1'b0;
            r_pa    <= '0;
            r_rdata <= '0;
            r_rdv   <= 1'b0;
            r_wdone <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_rd    <= w_rd;
            r_wr    <= w_wr;
            r_wdata <= w_wdata;
            r_pv    <= w_pv;
            r_pa    <= w_pa;
            r_rdata <= w_rdata;
            r_rdv   <= w_rdv;
            r_wdone <= w_wdone;
            r_err   <= w_err;
            r_cnt   <= w_cnt;
        end
    end

    // Next-state, strobes, response pulses and timeout counter.
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_rd    = r_rd;
        w_wr    = r_wr;
        w_wdata = r_wdata;
        w_pv    = r_pv;
        w_pa    = r_pa;
        w_rdata = r_rdata;
        w_rdv   = 1'b0;
        w_wdone = 1'b0;
        w_err   = 1'b0;
        w_cnt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (cl_write && !w_wr_mis) begin
                    w_state = WR_REQ;
                    w_addr  = w_wa;
                    w_wr    = 1'b1;
                    w_wdata = cl_writedata;
                    w_cnt   = '0;
                end else if (cl_read && !w_rd_mis) begin
                    w_state = RD_REQ;
                    w_addr  = w_ra;
                    w_rd    = 1'b1;
                end
                if (cl_write && !w_wr_mis && cl_read && !w_rd_mis) begin
                    w_pv = 1'b1;
                    w_pa = w_ra;
                end
                if (cl_write && w_wr_mis) begin
                    w_err = 1'b1;
                end
                if (cl_read && w_rd_mis) begin
                    w_err   = 1'b1;
                    w_rdv   = 1'b1;
                    w_rdata = '0;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    w_wr    = 1'b0;
                    w_wdone = 1'b1;
                    if (r_pv) begin
                        w_state = RD_REQ;
                        w_addr  = r_pa;
                        w_rd    = 1'b1;
                        w_pv    = 1'b0;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (w_to) begin
                    w_wr    = 1'b0;
                    w_err   = 1'b1;
                    w_pv    = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    w_rd = 1'b0;
                    if (avm_readdatavalid) begin
                        w_rdata = avm_readdata;
                        w_rdv   = 1'b1;
                        w_state = IDLE;
                    end else begin
                        w_state = RD_WAIT;
                        w_cnt   = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    w_rdata = avm_readdata;
                    w_rdv   = 1'b1;
                    w_state = IDLE;
                end else if (w_to) begin
                    w_rdata = '0;
                    w_rdv   = 1'b1;
                    w_err   = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign cl_ready         = rst && (r_state == IDLE) && !r_pv;
    assign cl_readdata      = r_rdata;
    assign cl_readdatavalid = r_rdv;
    assign cl_writedone     = r_wdone;
    assign cl_error         = r_err;
    assign avm_address      = r_addr;
    assign avm_read         = r_rd;
    assign avm_write        = r_wr;
    assign avm_writedata    = r_wdata;

`ifdef KNN_MEM_BRIDGE_STATS_EN
    logic [31:0] r_st_rd;
    logic [31:0] r_st_wr;
    logic [31:0] r_st_stall;
    logic        w_stall;

    assign w_stall = (r_rd || r_wr) && avm_waitrequest;

    // Saturating activity counters; errored reads are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st_rd    <= '0;
            r_st_wr    <= '0;
            r_st_stall <= '0;
        end else begin
            if (r_rdv && !r_err && r_st_rd != '1) begin
                r_st_rd <= r_st_rd + 1'b1;
            end
            if (r_wdone && r_st_wr != '1) begin
                r_st_wr <= r_st_wr + 1'b1;
            end
            if (w_stall && r_st_stall != '1) begin
                r_st_stall <= r_st_stall + 1'b1;
            end
        end
    end

    assign stat_reads        = r_st_rd;
    assign stat_writes       = r_st_wr;
    assign stat_stall_cycles = r_st_stall;
`endif

endmodule

// File: tb/tb_knn_mem_bridge.sv
// Scoreboard bench for knn_mem_bridge with a scripted Avalon memory.
// Stimulus pushes expectations; memory and monitor processes check them.
module tb_knn_mem_bridge;

    localparam int W  = 16;
    localparam int AW = 25;
    localparam int VW = 21;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cl_read = 1'b0;
    logic [AW-1:0] cl_readaddress = '0;
    logic          cl_write = 1'b0;
    logic [AW-1:0] cl_writeaddress = '0;
    logic [W-1:0]  cl_writedata = '0;
    logic          cl_ready;
    logic [W-1:0]  cl_readdata;
    logic          cl_readdatavalid;
    logic          cl_writedone;
    logic          cl_error;
    logic [VW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [W-1:0]  avm_writedata;
    logic          avm_waitrequest = 1'b0;
    logic [W-1:0]  avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;

    knn_mem_bridge #(.W(W), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .cl_read           (cl_read),
        .cl_readaddress    (cl_readaddress),
        .cl_write          (cl_write),
        .cl_writeaddress   (cl_writeaddress),
        .cl_writedata      (cl_writedata),
        .cl_ready          (cl_ready),
        .cl_readdata       (cl_readdata),
        .cl_readdatavalid  (cl_readdatavalid),
        .cl_writedone      (cl_writedone),
        .cl_error          (cl_error),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr;
        int addr;
        int data;
    } av_t;

    av_t q_av[$];
    int  q_rd[$];
    int  q_wd[$];
    bit  q_err[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc = 0;
    int last_rdv = 0;
    int last_err = 0;

    int cfg_stall = 0;
    int cfg_lat = 1;
    int cfg_rdata = 0;
    int stray_req = 0;
    int stray_ack = 0;

    int  m_left = 0;
    int  m_strobes = 0;
    int  m_rdv_in = 0;
    int  m_rdv_data = 0;
    bit  m_in = 0;
    av_t m_cap;
    av_t m_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Scripted Avalon slave: stalls, latency and stability checks.
    initial begin
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                avm_readdatavalid = 1'b1;
                avm_readdata = 16'hDEAD;
            end
            if (m_rdv_in > 0) begin
                m_rdv_in--;
                if (m_rdv_in == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = W'(m_rdv_data);
                end
            end
            if (!rst) begin
                m_in = 0;
                avm_waitrequest = 1'b0;
            end else if (avm_read || avm_write) begin
                if (!m_in) begin
                    m_in = 1;
                    m_cap.wr = avm_write;
                    m_cap.addr = int'(avm_address);
                    m_cap.data = int'(avm_writedata);
                    m_left = cfg_stall;
                    m_strobes = 0;
                end else begin
                    chk("hold_kind", int'(avm_write), int'(m_cap.wr));
                    chk("hold_addr", int'(avm_address), m_cap.addr);
                    if (m_cap.wr)
                        chk("hold_data", int'(avm_writedata), m_cap.data);
                end
                m_strobes++;
                if (m_left > 0) begin
                    avm_waitrequest = 1'b1;
                    m_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    m_in = 0;
                    if (q_av.size() == 0) begin
                        bad("unexpected_avm");
                    end else begin
                        m_e = q_av.pop_front();
                        chk("avm_kind", int'(avm_write), int'(m_e.wr));
                        chk("avm_addr", int'(avm_address), m_e.addr);
                        if (m_e.wr)
                            chk("avm_wdata", int'(avm_writedata), m_e.data);
                        chk("strobe_cycles", m_strobes, cfg_stall + 1);
                    end
                    if (avm_read) begin
                        if (cfg_lat == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata = W'(cfg_rdata);
                        end else if (cfg_lat > 0) begin
                            m_rdv_in = cfg_lat;
                            m_rdv_data = cfg_rdata;
                        end
                    end
                end
            end else begin
                m_in = 0;
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: pop and compare on every client-side response pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (cl_readdatavalid) begin
                last_rdv = cyc;
                if (q_rd.size() == 0) bad("unexpected_rdv");
                else chk("rdata", int'(cl_readdata), q_rd.pop_front());
            end
            if (cl_writedone) begin
                if (q_wd.size() == 0) bad("unexpected_wdone");
                else void'(q_wd.pop_front());
            end
            if (cl_error) begin
                last_err = cyc;
                if (q_err.size() == 0) bad("unexpected_err");
                else chk("err_rdv", int'(cl_readdatavalid),
                         int'(q_err.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cl_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cl_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_wait: got 0 expected 1");
        end
    endtask

    task automatic req(input bit rd, input int ra, input bit wr,
                       input int wa, input int wd);
        wait_ready();
        cl_read = rd;
        cl_readaddress = AW'(ra);
        cl_write = wr;
        cl_writeaddress = AW'(wa);
        cl_writedata = W'(wd);
        @(negedge clk);
        acc = cyc;
        cl_read = 1'b0;
        cl_write = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((q_rd.size() != 0 || q_wd.size() != 0 ||
                q_err.size() != 0 || q_av.size() != 0 || !cl_ready)
               && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            tests++;
            fails++;
            $display("FAIL %s: got no completion expected drain", name);
            q_rd.delete();
            q_wd.delete();
            q_err.delete();
            q_av.delete();
        end
        tick(2);
    endtask

    task automatic push_av(input bit wr, input int addr, input int data);
        av_t e;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        q_av.push_back(e);
    endtask

    initial begin
        tick(3);
        chk("rst_ready", int'(cl_ready), 0);
        chk("rst_avm_read", int'(avm_read), 0);
        chk("rst_avm_write", int'(avm_write), 0);
        chk("rst_rdv", int'(cl_readdatavalid), 0);
        chk("rst_rdata", int'(cl_readdata), 0);
        rst = 1'b1;
        tick(1);
        chk("ready_after_rst", int'(cl_ready), 1);

        cfg_lat = 2;
        cfg_rdata = 'hBEEF;
        push_av(0, 3, 0);
        q_rd.push_back('hBEEF);
        req(1, 48, 0, 0, 0);
        wait_done("read48");
        chk("ready_after_read", int'(cl_ready), 1);

        cfg_lat = 1;
        cfg_rdata = 'h5A5A;
        push_av(0, 8, 0);
        q_rd.push_back('h5A5A);
        req(1, 'h80, 0, 0, 0);
        wait_done("read_minlat");
        chk("rd_latency", last_rdv - acc, 2);

        cfg_lat = 0;
        cfg_rdata = 'h0F0F;
        push_av(0, 1, 0);
        q_rd.push_back('h0F0F);
        req(1, 16, 0, 0, 0);
        wait_done("read_zerolat");
        chk("rd_zero_latency", last_rdv - acc, 1);

        cfg_stall = 3;
        push_av(1, 16, 'h1234);
        q_wd.push_back(1);
        req(0, 0, 1, 256, 'h1234);
        wait_done("write_stall");
        cfg_stall = 0;

        cfg_lat = 1;
        cfg_rdata = 'h3C3C;
        push_av(1, 4, 'hAAAA);
        push_av(0, 2, 0);
        q_wd.push_back(1);
        q_rd.push_back('h3C3C);
        req(1, 32, 1, 64, 'hAAAA);
        for (int i = 0; i < 3; i++) begin
            chk("collide_ready", int'(cl_ready), 0);
            tick(1);
        end
        wait_done("collision");

        q_rd.push_back(0);
        q_err.push_back(1);
        req(1, 5, 0, 0, 0);
        wait_done("misaligned_rd");

        q_err.push_back(0);
        req(0, 0, 1, 3, 'hFFFF);
        wait_done("misaligned_wr");

        cfg_lat = 1;
        cfg_rdata = 'h7777;
        push_av(0, 2, 0);
        q_rd.push_back('h7777);
        req(1, 'h20, 0, 0, 0);
        wait_done("read_pre_to");

        cfg_lat = -1;
        push_av(0, 16, 0);
        q_rd.push_back(0);
        q_err.push_back(1);
        req(1, 'h100, 0, 0, 0);
        wait_done("read_timeout");
        chk("rd_timeout_lat", last_err - acc, TO + 1);

        cfg_lat = 1;
        cfg_rdata = 'h1357;
        push_av(0, 3, 0);
        q_rd.push_back('h1357);
        req(1, 'h30, 0, 0, 0);
        wait_done("read_post_to");

        cfg_stall = 1000;
        q_err.push_back(0);
        req(1, 'h50, 1, 'h60, 'h4242);
        wait_done("write_timeout");
        cfg_stall = 0;
        tick(4);

        stray_req++;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stray_ignored", int'(cl_readdatavalid), 0);
        end

        cfg_stall = 1000;
        req(0, 0, 1, 'h90, 'h5555);
        tick(2);
        rst = 1'b0;
        #1;
        chk("rst_drop_write", int'(avm_write), 0);
        chk("rst_ready_low", int'(cl_ready), 0);
        tick(2);
        rst = 1'b1;
        cfg_stall = 0;
        tick(2);

        cfg_lat = 5;
        cfg_rdata = 'hCAFE;
        push_av(0, 4, 0);
        req(1, 'h40, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        #1;
        chk("rst_rdwait_read", int'(avm_read), 0);
        chk("rst_rdwait_ready", int'(cl_ready), 0);
        tick(2);
        rst = 1'b1;
        tick(6);
        chk("ready_after_rst2", int'(cl_ready), 1);

        cfg_lat = 1;
        cfg_rdata = 'h2468;
        push_av(0, 7, 0);
        q_rd.push_back('h2468);
        req(1, 'h70, 0, 0, 0);
        wait_done("read_after_rst");

        chk("left_rd", q_rd.size(), 0);
        chk("left_wd", q_wd.size(), 0);
        chk("left_err", q_err.size(), 0);
        chk("left_av", q_av.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
